// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: bus bit positions, bus widths
// and the arbiter state encoding.
package mem_bus_pkg;

    // Bus widths
    localparam int unsigned REQ_BUS_W = 66;
    localparam int unsigned RSP_BUS_W = 33;

    // Request bus field positions
    localparam int unsigned REQ     = 65;
    localparam int unsigned WE      = 64;
    localparam int unsigned ADDR_HI = 63;
    localparam int unsigned ADDR_LO = 32;
    localparam int unsigned DATA_HI = 31;
    localparam int unsigned DATA_LO = 0;

    // Response bus field positions
    localparam int unsigned ACK = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrantI = 2'd1,
        StGrantD = 2'd2,
        StDone   = 2'd3
    } arb_state_e;

    // One-hot owner {D, I} for a given state
    function automatic logic [1:0] grant_of(arb_state_e st);
        return {st == StGrantD, st == StGrantI};
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Transaction timeout counter: held at zero while cleared, counts enabled
// cycles and reports expiry once the count equals the limit.
module arb_timeout_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == limit_i);

    // Next count: clear dominates; stop at the limit so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for a single memory port.
// Latches one request at a time, routes ack/rdata back to the owner and
// aborts with a synthetic {1, ERR_DATA} response when memory does not answer.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin arbitration between
// simultaneous requests; otherwise D-cache has fixed priority.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    parameter logic [31:0]  ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [REQ_BUS_W-1:0] Icache_bus_out,
    output logic [RSP_BUS_W-1:0] Icache_bus_in,
    input  logic [REQ_BUS_W-1:0] Dcache_bus_out,
    output logic [RSP_BUS_W-1:0] Dcache_bus_in,
    output logic [REQ_BUS_W-1:0] Mem_bus_out,
    input  logic [RSP_BUS_W-1:0] Mem_bus_in,
    output logic [1:0]           o_grant,
    output logic                 o_timeout
);

    arb_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic i_req, d_req, pick_d;
    logic in_grant, mem_ack, expired;
    logic [RSP_BUS_W-1:0] owner_rsp;

    assign i_req    = Icache_bus_out[REQ];
    assign d_req    = Dcache_bus_out[REQ];
    assign in_grant = (state_q == StGrantI) || (state_q == StGrantD);
    assign mem_ack  = Mem_bus_in[ACK];

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the D-cache was the last one granted
    logic last_d_q, last_d_d;

    // Winner selection: a lone requester always wins, a tie goes to the one not last served
    always_comb begin
        pick_d = d_req && (!i_req || !last_d_q);
    end

    // Pointer follows every grant issued from idle
    always_comb begin
        last_d_d = last_d_q;
        if (state_q == StIdle && (i_req || d_req)) begin
            last_d_d = pick_d;
        end
    end

    // Last-served pointer register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Winner selection: D-cache always beats I-cache
    always_comb begin
        pick_d = d_req;
    end
`endif

    // Counter runs only while a request is on the memory bus
    arb_timeout_cnt u_timeout_cnt (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .clear_i   (!in_grant),
        .enable_i  (in_grant && !mem_ack),
        .limit_i   (8'(TIMEOUT_CYCLES)),
        .expired_o (expired)
    );

    // Next state and request latch
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d = pick_d ? StGrantD : StGrantI;
                    if (pick_d) begin
                        {we_d, addr_d, wdata_d} = Dcache_bus_out[WE:DATA_LO];
                    end else begin
                        {we_d, addr_d, wdata_d} = Icache_bus_out[WE:DATA_LO];
                    end
                end
            end
            StGrantI, StGrantD: begin
                if (mem_ack || expired) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Requests are deliberately not sampled here
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs: memory request from registers, response routed to the owner only
    always_comb begin
        Icache_bus_in = '0;
        Dcache_bus_in = '0;
        // A real ack wins over a coincident timeout
        owner_rsp = (!mem_ack && expired) ? {1'b1, ERR_DATA} : Mem_bus_in;
        if (state_q == StGrantI) begin
            Icache_bus_in = owner_rsp;
        end
        if (state_q == StGrantD) begin
            Dcache_bus_in = owner_rsp;
        end
        Mem_bus_out = in_grant ? {1'b1, we_q, addr_q, wdata_q} : '0;
        o_grant     = grant_of(state_q);
        o_timeout   = in_grant && expired && !mem_ack;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized
// sessions, compared each cycle against a transaction-level expectation.
module tb_mem_bus_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [65:0] Icache_bus_out, Dcache_bus_out, Mem_bus_out;
    logic [32:0] Icache_bus_in, Dcache_bus_in, Mem_bus_in;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    bit last_d_model = 1'b0;

    always #5 Clk = ~Clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Icache_bus_out (Icache_bus_out),
        .Icache_bus_in  (Icache_bus_in),
        .Dcache_bus_out (Dcache_bus_out),
        .Dcache_bus_in  (Dcache_bus_in),
        .Mem_bus_out    (Mem_bus_out),
        .Mem_bus_in     (Mem_bus_in),
        .o_grant        (o_grant),
        .o_timeout      (o_timeout)
    );

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] rnd_fields();
        logic [31:0] a, d;
        a = $urandom();
        d = $urandom();
        return {1'($urandom_range(0, 1)), a, d};
    endfunction

    // Which requester wins a tie under the configured policy
    function automatic bit tie_goes_to_d();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_d_model;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".grant"}, 66'(o_grant), 66'd0);
        chk({tag, ".memreq"}, 66'(Mem_bus_out[65]), 66'd0);
        chk({tag, ".irsp"}, 66'(Icache_bus_in), 66'd0);
        chk({tag, ".drsp"}, 66'(Dcache_bus_in), 66'd0);
        chk({tag, ".tmo"}, 66'(o_timeout), 66'd0);
    endtask

    // One session from idle: present requests, then serve every pending
    // requester in policy order. dly = cycles after grant until memory acks;
    // dly > TO means memory never acks.
    task automatic serve_session(input bit ri, input bit rd,
                                 input logic [64:0] fi, input logic [64:0] fd,
                                 input int dly_i, input int dly_d,
                                 input logic [31:0] ack_rdata);
        bit          pend_i, pend_d, win_d, real_ack;
        logic [64:0] lat;
        logic [31:0] rv;
        logic [32:0] exp_rsp;
        int          dly, last_g;
        pend_i = ri;
        pend_d = rd;
        @(negedge Clk);
        Icache_bus_out = {ri, fi};
        Dcache_bus_out = {rd, fd};
        Mem_bus_in     = {1'b1, 32'($urandom())};  // stray ack while idle
        #1 chk_quiet("idle");
        while (pend_i || pend_d) begin
            win_d    = pend_d && (!pend_i || tie_goes_to_d());
            lat      = win_d ? fd : fi;
            dly      = win_d ? dly_d : dly_i;
            real_ack = (dly <= TO);
            last_g   = real_ack ? dly : TO;
            for (int g = 0; g <= last_g; g++) begin
                @(negedge Clk);
                rv = (g == dly) ? ack_rdata : 32'($urandom());
                Mem_bus_in = {(g == dly), rv};
                // Owner scribbles on its bus after the grant edge
                if (win_d) Dcache_bus_out = {1'b1, rnd_fields()};
                else       Icache_bus_out = {1'b1, rnd_fields()};
                #1;
                if (g == last_g) exp_rsp = real_ack ? {1'b1, rv} : {1'b1, ERR};
                else             exp_rsp = {1'b0, rv};
                chk("grant", 66'(o_grant), win_d ? 66'd2 : 66'd1);
                chk("memout", Mem_bus_out, {1'b1, lat});
                chk("owner_rsp", 66'(win_d ? Dcache_bus_in : Icache_bus_in), 66'(exp_rsp));
                chk("loser_rsp", 66'(win_d ? Icache_bus_in : Dcache_bus_in), 66'd0);
                chk("timeout", 66'(o_timeout), 66'(g == last_g && !real_ack));
            end
            last_d_model = win_d;
            if (win_d) pend_d = 1'b0;
            else       pend_i = 1'b0;
            @(negedge Clk);
            if (win_d) Dcache_bus_out = '0;
            else       Icache_bus_out = '0;
            Mem_bus_in = {1'b1, 32'($urandom())};
            #1 chk_quiet("done");
            @(negedge Clk);
            Mem_bus_in = {1'b1, 32'($urandom())};
            #1 chk_quiet("idle2");
        end
    endtask

    initial begin
        Rst            = 1'b1;
        Icache_bus_out = '0;
        Dcache_bus_out = '0;
        Mem_bus_in     = '0;
        @(negedge Clk);
        #1;
        chk("rst.memout", Mem_bus_out, 66'd0);
        chk("rst.grant", 66'(o_grant), 66'd0);
        chk("rst.irsp", 66'(Icache_bus_in), 66'd0);
        chk("rst.drsp", 66'(Dcache_bus_in), 66'd0);
        chk("rst.tmo", 66'(o_timeout), 66'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // Single I read, ack at grant+2
        serve_session(1'b1, 1'b0, {1'b0, 32'h0000_0100, 32'h0}, '0, 2, 0, 32'h1234_5678);
        // Simultaneous requests
        serve_session(1'b1, 1'b1, rnd_fields(), rnd_fields(), 1, 3, 32'h0BAD_F00D);
        serve_session(1'b1, 1'b1, rnd_fields(), rnd_fields(), 0, 2, 32'h5555_AAAA);
        // D write; owner changes its bus after grant
        serve_session(1'b0, 1'b1, '0, {1'b1, 32'h8000_0000, 32'hCAFE_F00D}, 0, 3, 32'h0);
        // Memory never answers
        serve_session(1'b0, 1'b1, '0, rnd_fields(), 0, TO + 1, 32'h0);
        serve_session(1'b1, 1'b0, rnd_fields(), '0, TO + 2, 0, 32'h0);
        // Ack on the same cycle the counter expires
        serve_session(1'b1, 1'b0, rnd_fields(), '0, TO, 0, 32'h7777_1234);

        // Asynchronous reset in the middle of a D grant
        @(negedge Clk);
        Dcache_bus_out = {1'b1, 1'b1, 32'h4000_0000, 32'h1111_2222};
        Icache_bus_out = '0;
        Mem_bus_in     = '0;
        @(negedge Clk);
        #1 chk("pre_rst.grant", 66'(o_grant), 66'd2);
        #1 Rst = 1'b1;
        #1;
        chk("mid_rst.memout", Mem_bus_out, 66'd0);
        chk("mid_rst.grant", 66'(o_grant), 66'd0);
        chk("mid_rst.drsp", 66'(Dcache_bus_in), 66'd0);
        @(negedge Clk);
        Rst            = 1'b0;
        Dcache_bus_out = '0;
        last_d_model   = 1'b0;
        serve_session(1'b1, 1'b0, rnd_fields(), '0, 1, 0, 32'h2468_ACE0);

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            bit ri, rd;
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) ri = 1'b1;
            serve_session(ri, rd, rnd_fields(), rnd_fields(),
                          $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
                          32'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
